// File: rtl/aes_iter_enc.sv
// Iterative AES encryptor: one round per enabled clock, round keys expanded on the fly.
// KEY_BITS selects AES-128 (10 rounds) or AES-256 (14 rounds); valid/ready on both sides.
module aes_iter_enc #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_BITS-1:0] CipherKey_i,
  input  logic [127:0]        Data_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        AES_o,
  output logic                busy
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_enc: KEY_BITS must be 128 or 256");
  end

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte 0 sits in the low bits, so RotWord moves the low byte to the top.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  logic [1:0]          fsm;
  logic [3:0]          round;
  logic [7:0]          rcon;
  logic [127:0]        st;
  logic [KEY_BITS-1:0] kw;

  logic [127:0]        sr;
  logic [127:0]        mc;
  logic [127:0]        rk;
  logic [127:0]        nxt_st;
  logic [KEY_BITS-1:0] kw_nxt;
  logic                rcon_step;

  // SubBytes fused with ShiftRows: byte (r,c) lives at index r+4c.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr[8*(r+4*c) +: 8] = sbox(st[8*(r+4*((c+r)%4)) +: 8]);
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[32*c      +: 8];
    assign a1 = sr[32*c + 8  +: 8];
    assign a2 = sr[32*c + 16 +: 8];
    assign a3 = sr[32*c + 24 +: 8];
    assign mc[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  if (KEY_BITS == 128) begin : g_k128
    logic [31:0] t, n0, n1, n2, n3;
    assign t  = sub_word(rot_word(kw[127:96])) ^ {24'h0, rcon};
    assign n0 = kw[31:0]   ^ t;
    assign n1 = kw[63:32]  ^ n0;
    assign n2 = kw[95:64]  ^ n1;
    assign n3 = kw[127:96] ^ n2;
    assign rk        = {n3, n2, n1, n0};
    assign kw_nxt    = {n3, n2, n1, n0};
    assign rcon_step = 1'b1;
  end else begin : g_k256
    // Round 1 uses the upper key half as-is; afterwards each round generates four
    // fresh words, with RotWord+Rcon on even rounds and SubWord alone on odd rounds.
    logic        first, gen_rot;
    logic [31:0] t, n0, n1, n2, n3;
    logic [127:0] fresh;
    assign first   = (round == 4'd1);
    assign gen_rot = ~round[0];
    assign t  = sub_word(gen_rot ? rot_word(kw[255:224]) : kw[255:224])
              ^ {24'h0, (gen_rot ? rcon : 8'h00)};
    assign n0 = kw[31:0]   ^ t;
    assign n1 = kw[63:32]  ^ n0;
    assign n2 = kw[95:64]  ^ n1;
    assign n3 = kw[127:96] ^ n2;
    assign fresh     = {n3, n2, n1, n0};
    assign rk        = first ? kw[255:128] : fresh;
    assign kw_nxt    = first ? kw : {fresh, kw[255:128]};
    assign rcon_step = gen_rot;
  end

  // MixColumns is dropped in the final round.
  assign nxt_st = ((round == NR) ? sr : mc) ^ rk;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= S_IDLE;
      round <= 4'd0;
      rcon  <= 8'h00;
      st    <= '0;
      kw    <= '0;
    end else if (en) begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            st    <= Data_i ^ CipherKey_i[127:0];
            kw    <= CipherKey_i;
            round <= 4'd1;
            rcon  <= 8'h01;
            fsm   <= S_RUN;
          end
        end
        S_RUN: begin
          st <= nxt_st;
          kw <= kw_nxt;
          if (rcon_step) rcon <= xtime(rcon);
          if (round == NR) begin
            round <= 4'd0;
            fsm   <= S_DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == S_IDLE);
  assign out_valid = (fsm == S_DONE);
  assign busy      = (fsm != S_IDLE);
  assign AES_o     = st;

endmodule

// File: tb/tb_aes_iter_enc.sv
// Self-checking bench for aes_iter_enc: one AES-128 and one AES-256 instance, each
// compared with a FIPS-197 style reference model built from GF(2^8) arithmetic.
module tb_aes_iter_enc;

  logic         clk = 1'b0;
  logic         rst_n, en128, en256, in_valid, out_ready, sel;
  logic [127:0] data_p, key128_p;
  logic [255:0] key256_p;
  logic         ir128, ir256, ov128, ov256, busy128, busy256;
  logic [127:0] ct128, ct256;
  logic         ir_s, ov_s, busy_s;
  logic [127:0] ct_s;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sbox_t [256];

  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_iter_enc #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .en(en128), .in_valid(in_valid), .in_ready(ir128),
    .CipherKey_i(key128_p), .Data_i(data_p), .out_valid(ov128), .out_ready(out_ready),
    .AES_o(ct128), .busy(busy128)
  );

  aes_iter_enc #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .en(en256), .in_valid(in_valid), .in_ready(ir256),
    .CipherKey_i(key256_p), .Data_i(data_p), .out_valid(ov256), .out_ready(out_ready),
    .AES_o(ct256), .busy(busy256)
  );

  assign ir_s   = sel ? ir256   : ir128;
  assign ov_s   = sel ? ov256   : ov128;
  assign busy_s = sel ? busy256 : busy128;
  assign ct_s   = sel ? ct256   : ct128;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197 byte order, byte 0 = MSB) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input int nk, input logic [255:0] k, input logic [127:0] p);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] r;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_w(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int rnd = 0; rnd <= nr; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
        for (int rr = 0; rr < 4; rr++)
          for (int c = 0; c < 4; c++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
        if (rnd < nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = s[rr+4*c] ^ w[4*rnd+c][31-8*rr -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- port byte-order helpers and stimulus tasks ----------------
  function automatic logic [127:0] p128(input logic [127:0] lit);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = lit[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] p256(input logic [255:0] lit);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = lit[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic [255:0] k, input logic [127:0] p);
    data_p   = p128(p);
    key256_p = p256(k);
    key128_p = p128(k[255:128]);
  endtask

  task automatic use_dut(input logic s);
    sel   = s;
    en128 = !s;
    en256 = s;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!ov_s && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run_block(input string tag, input logic [255:0] k, input logic [127:0] p,
                           input logic [127:0] exp, input int nr);
    int cnt;
    drive(k, p);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check({tag, "_in_ready"}, ir_s, 1);
    @(negedge clk);
    in_valid = 1'b0;
    drive(rand256(), rand128());
    wait_valid(cnt);
    check({tag, "_latency"}, cnt, nr);
    check({tag, "_ct"}, ct_s, p128(exp));
    check({tag, "_busy_in_done"}, {busy_s, ir_s}, 2'b10);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drained"}, {ov_s, ir_s, busy_s}, 3'b010);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] k;
    logic [127:0] p, held;
    logic [7:0]   inv;
    logic         stable, saw;
    int cnt, n_acc, n_out, cyc;
    int acc [2];
    logic [127:0] outs [2];

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst_n = 1'b0; en128 = 1'b0; en256 = 1'b0; sel = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; data_p = '0; key128_p = '0; key256_p = '0;
    repeat (2) @(negedge clk);
    check("rst_128", {ir128, ov128, busy128, ct128}, {3'b100, 128'h0});
    check("rst_256", {ir256, ov256, busy256, ct256}, {3'b100, 128'h0});
    rst_n = 1'b1;
    @(negedge clk);

    use_dut(1'b0); run_block("appb", KEY_B, PT_B, CT_B, 10);
    use_dut(1'b1); run_block("c3", KEY_C3, PT_C, CT_C3, 14);

    for (int i = 0; i < 3; i++) begin
      k = rand256();
      p = rand128();
      use_dut(1'b0); run_block("rnd128", k, p, aes_ref(4, k, p), 10);
      use_dut(1'b1); run_block("rnd256", k, p, aes_ref(8, k, p), 14);
    end

    // Back-to-back: C.1 then App.B with in_valid held and out_ready high.
    use_dut(1'b0);
    drive(KEY_C1, PT_C);
    in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; n_out = 0; cyc = 0;
    while (n_out < 2 && cyc < 80) begin
      if (in_valid && ir_s && n_acc < 2) begin acc[n_acc] = cyc; n_acc++; end
      if (ov_s) begin outs[n_out] = ct_s; n_out++; end
      @(negedge clk);
      cyc++;
      if (n_acc == 1) drive(KEY_B, PT_B);
      if (n_acc == 2) in_valid = 1'b0;
    end
    check("b2b_count", n_out, 2);
    check("b2b_ct0", outs[0], p128(CT_C1));
    check("b2b_ct1", outs[1], p128(CT_B));
    check("b2b_spacing", acc[1] - acc[0], 12);
    out_ready = 1'b0;

    // Backpressure: hold DONE for 20 cycles, freeze with en low, then a 1-cycle drain.
    k = rand256(); p = rand128();
    drive(k, p);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cnt);
    check("bp_valid", ov_s, 1);
    held = ct_s; stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ct_s !== held || ir_s !== 1'b0 || ov_s !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_ct", ct_s, p128(aes_ref(4, k, p)));
    en128 = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_en_frozen", {ov_s, ir_s}, 2'b10);
    en128 = 1'b1;
    @(negedge clk);
    check("bp_drain", {ov_s, ir_s}, 2'b01);
    out_ready = 1'b0;

    // Clock enable toggled every other cycle on the AES-256 core.
    use_dut(1'b1);
    drive(KEY_C3, PT_C);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    en256 = 1'b0;
    cnt = 0;
    while (!ov_s && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (!ov_s) en256 = !en256;
    end
    check("en_toggle_latency", cnt, 28);
    check("en_toggle_ct", ct_s, p128(CT_C3));
    en256 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset pulse around round 5, then a fresh block.
    use_dut(1'b0);
    drive(KEY_B, PT_B);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {ir_s, ov_s, busy_s, ct_s}, {3'b100, 128'h0});
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov_s !== 1'b0) saw = 1'b1;
    end
    check("rst_no_valid", saw, 0);
    run_block("rst_appb", KEY_B, PT_B, CT_B, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
